// File: rtl/fc7_rm_rd_ctrl_if.sv
// Signal bundle for the burst read controller: the burst command, the RAM
// read port and the output stream.
interface fc7_rm_rd_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;

    // Controller side.
    modport master (
        input  start, base_addr, length, doutb, m_ready,
        output addrb, m_data, m_valid, m_last, busy, done
    );

    // Command source, RAM and stream sink side.
    modport slave (
        output start, base_addr, length, doutb, m_ready,
        input  addrb, m_data, m_valid, m_last, busy, done
    );
endinterface

// File: rtl/fc7_rm_rd_ctrl.sv
// Burst read controller: on start, reads `length` consecutive words from a
// fixed-latency RAM port (address wrapping at 2^ADDR_W) and streams them out
// over a valid/ready interface. Reads are only issued when the output FIFO
// has room for every read still in flight, so the FIFO can never overflow.
module fc7_rm_rd_ctrl #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fc7_rm_rd_ctrl_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic              r_done_zero;
    logic [RD_LAT-1:0] r_vld_sr;
    logic [RD_LAT-1:0] r_last_sr;
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_start_ok;
    logic              w_credit;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_fifo_wr;
    logic              w_fifo_rd;
    logic              w_head_last;
    logic [LAT_W-1:0]  w_inflight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_start_ok   = bus.start && (r_state == IDLE);
    assign w_issue      = (r_state == ISSUE) && w_credit;
    assign w_last_issue = (r_idx == r_len - LEN_W'(1));
    assign w_fifo_wr    = r_vld_sr[RD_LAT-1];
    assign w_fifo_rd    = bus.m_valid && bus.m_ready;
    assign w_head_last  = r_mem_last[r_rd_ptr];

    assign bus.addrb   = r_base + r_idx[ADDR_W-1:0];
    assign bus.m_valid = (r_count != '0);
    assign bus.m_data  = bus.m_valid ? r_mem_data[r_rd_ptr] : '0;
    assign bus.m_last  = bus.m_valid && w_head_last;
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done_zero || ((r_state == DRAIN) && w_fifo_rd && w_head_last);

    // Credit check: FIFO entries plus reads in flight must leave room for one more.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + LAT_W'(r_vld_sr[i]);
        end
        w_credit = (int'(r_count) + int'(w_inflight)) < FIFO_DEPTH;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok && (bus.length != '0)) w_state_nxt = ISSUE;
            ISSUE:   if (w_issue && w_last_issue)          w_state_nxt = DRAIN;
            DRAIN:   if (w_fifo_rd && w_head_last)         w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Latch the burst command on an accepted start and step the issue index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_done_zero <= 1'b0;
        end else begin
            r_done_zero <= w_start_ok && (bus.length == '0);
            if (w_start_ok) begin
                r_base <= bus.base_addr;
                r_len  <= bus.length;
                r_idx  <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + LEN_W'(1);
            end
        end
    end

    // Track issued reads (and which one is last) until their data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr  <= '0;
            r_last_sr <= '0;
        end else begin
            r_vld_sr[0]  <= w_issue;
            r_last_sr[0] <= w_issue && w_last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1];
                r_last_sr[i] <= r_last_sr[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous write and read keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_fifo_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage written with returning RAM data.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; r_count gates every use of it, so stale contents are never seen.
        if (w_fifo_wr) begin
            r_mem_data[r_wr_ptr] <= bus.doutb;
            r_mem_last[r_wr_ptr] <= r_last_sr[RD_LAT-1];
        end
    end
endmodule

// File: doc/fc7_rm_rd_ctrl.md
FC7_RM_RD_CTRL -- requirements
Module: fc7_rm_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32: RAM/stream data width.
REQ-003 SHALL have parameter RD_LAT, default 2: RAM read latency in cycles, from addrb to doutb.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries; must be at least RD_LAT+2.
REQ-005 SHALL have port clk, input, 1: the single clock, shared with the RAM read port.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: single-cycle pulse that begins a burst.
REQ-008 SHALL have port base_addr, input, ADDR_W: first word address; sampled on an accepted start.
REQ-009 SHALL have port length, input, ADDR_W+1: word count, 0..2^ADDR_W; sampled on an accepted start.
REQ-010 SHALL have port addrb, output, ADDR_W: RAM read address.
REQ-011 SHALL have port doutb, input, DATA_W: RAM read data; valid RD_LAT cycles after addrb.
REQ-012 SHALL have port m_data, output, DATA_W: stream data.
REQ-013 SHALL have port m_valid, output, 1: stream valid.
REQ-014 SHALL have port m_ready, input, 1: stream ready.
REQ-015 SHALL have port m_last, output, 1: marks the final word of a burst.
REQ-016 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when the last word is accepted downstream.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE and DRAIN.
REQ-019 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-020 SHALL move IDLE->ISSUE on start with length>0.
REQ-021 SHALL pulse done on the cycle after a start with length==0, issue no reads, and stay in IDLE.
REQ-022 SHALL issue one read in ISSUE when (fifo_count + inflight) < FIFO_DEPTH, where inflight is the number of issued reads whose data has not yet returned (0..RD_LAT).
REQ-023 SHALL drive addrb = (base_addr + issue_idx) mod 2^ADDR_W, so addresses wrap from 2^ADDR_W-1 to 0.
REQ-024 SHALL, for a read issued at cycle t, write doutb into the FIFO at cycle t+RD_LAT; issue_valid is tracked by an RD_LAT-deep shift register.
REQ-025 SHALL use addrb only when a read is issued, because the RAM read enable is tied high; cycles with no issue produce no FIFO write.
REQ-026 SHALL move ISSUE->DRAIN after issuing read number length.
REQ-027 SHALL move DRAIN->IDLE when the word with m_last is transferred (m_valid & m_ready), and pulse done on that same cycle.
REQ-028 SHALL set m_valid = fifo not empty, with m_data taken from the FIFO head.
REQ-029 SHALL allow a FIFO write and a FIFO read in the same cycle, leaving the count unchanged.
REQ-030 SHALL never overflow the FIFO; the credit check in REQ-022 guarantees this.
REQ-031 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-032 SHALL assert m_last only on word number length of the burst.
REQ-033 SHALL sustain one word per cycle when m_ready is held high.
REQ-034 SHALL give a first-word latency of RD_LAT+1 cycles from the accepted start to m_valid.
REQ-035 SHALL drive busy = (state != IDLE).

Reset
REQ-036 SHALL, while rst_n=0, asynchronously force: state IDLE, FIFO empty, inflight 0, m_valid 0, m_last 0, busy 0, done 0, addrb 0.
REQ-037 SHALL abort any burst in progress when rst_n is asserted mid-burst, and discard data returning after reset.
REQ-038 SHALL accept start no earlier than the first clk edge after rst_n deasserts.

Verification
REQ-039 SHALL pass: RAM preloaded with data = address, base 0x010, length 8, m_ready=1 -> m_data 0x10..0x17 on consecutive cycles, m_valid first high 3 cycles after start, m_last and done on word 8.
REQ-040 SHALL pass: base 0x7FE, length 4 -> addrb sequence 0x7FE, 0x7FF, 0x000, 0x001, and data order preserved.
REQ-041 SHALL pass: length 16 with m_ready toggled randomly -> all 16 words in order, no drop or duplicate, FIFO count never above 4.
REQ-042 SHALL pass: length 0 -> done one cycle after start, no m_valid, busy stays 0.
REQ-043 SHALL pass: rst_n asserted at word 5 of a length-10 burst -> outputs zero immediately; a new burst of length 2 after reset returns only its own 2 words.
REQ-044 SHALL pass: start pulsed while busy -> ignored, and the current burst completes unchanged.
